// File: rtl/wr_ptr_full.sv
// -----------------------------------------------------------------------------
// wr_ptr_full
//
// Write-side pointer and full-flag logic of an asynchronous FIFO. It keeps the
// binary write pointer and its Gray image, and drives the write address and
// write strobe into the dual-port RAM. It receives the read pointer after that
// pointer has passed through the 2-flop synchronizer into this clock domain.
// From it, the block derives registered full, almost-full and fill-level
// outputs.
//
// Parameters:
//   ADDR_W        RAM address width (depth = 2**ADDR_W, pointers ADDR_W+1 bits).
//                 Must be at least 2.
//   AFULL_THRESH  fill level at or above which walmost_full asserts
//                 (1..2**ADDR_W).
//
// Ports:
//   clk           write-domain clock
//   rst_n         synchronous, active-low reset
//   wr_en         write request from the producer
//   wq2_rptr      Gray read pointer, already synchronized into clk
//   wr_accept     RAM write strobe (combinational: wr_en & ~wfull)
//   waddr         RAM write address (low bits of the binary write pointer)
//   wptr          registered Gray write pointer, sent to the read side
//   wfull         registered full flag
//   walmost_full  registered almost-full flag
//   woverflow     sticky flag, set by a write attempt while full
//                 (present only when WR_OVERFLOW_FLAG_EN is defined)
//   wlevel        registered fill level 0..2**ADDR_W (pessimistic)
//
// Build option: define WR_OVERFLOW_FLAG_EN to add the woverflow output.
// -----------------------------------------------------------------------------
module wr_ptr_full #(
  parameter int ADDR_W       = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wq2_rptr,
  output logic              wr_accept,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull,
  output logic              walmost_full,
`ifdef WR_OVERFLOW_FLAG_EN
  output logic              woverflow,
`endif
  output logic [ADDR_W:0]   wlevel
);

  // One extra bit lets the threshold 2**ADDR_W compare without truncation.
  localparam logic [ADDR_W+1:0] AFULL_T = (ADDR_W+2)'(AFULL_THRESH);

  logic [ADDR_W:0] wbin_reg;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] wgray_next;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] wlevel_next;
  logic [ADDR_W:0] full_cmp;
  logic            wfull_next;
  logic            walmost_full_next;

  // Writes are blocked during reset, so the RAM is not touched on that edge.
  assign wr_accept = wr_en & ~wfull & rst_n;
  assign waddr     = wbin_reg[ADDR_W-1:0];

  assign wbin_next  = wbin_reg + {{ADDR_W{1'b0}}, wr_accept};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Gray-to-binary conversion of the synchronized read pointer. Each binary
  // bit is the XOR of all Gray bits from the MSB down to that bit.
  assign rbin[ADDR_W] = wq2_rptr[ADDR_W];
  generate
    for (genvar gi = ADDR_W - 1; gi >= 0; gi--) begin : g_gray2bin
      assign rbin[gi] = rbin[gi+1] ^ wq2_rptr[gi];
    end
  endgenerate

  // The FIFO is full when the write pointer is exactly one lap (2**ADDR_W)
  // ahead of the read pointer. In Gray code, adding 2**ADDR_W inverts the top
  // two bits and leaves the lower bits unchanged.
  assign full_cmp   = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
  assign wfull_next = (wgray_next == full_cmp);

  // The synchronized read pointer lags the real one. The level computed here
  // can therefore be too high but never too low, which is the safe direction.
  assign wlevel_next       = wbin_next - rbin;
  assign walmost_full_next = ({1'b0, wlevel_next} >= AFULL_T);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin_reg     <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin_reg     <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wlevel       <= wlevel_next;
    end
  end

`ifdef WR_OVERFLOW_FLAG_EN
  // Sticky record that a write was dropped. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      woverflow <= 1'b0;
    end else if (wr_en && wfull) begin
      woverflow <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/wr_ptr_full.md
# wr_ptr_full

Write-domain pointer and full-flag generator for the asynchronous FIFO. It keeps the binary and Gray write pointers and drives the write address and write strobe into the dual-port RAM. It consumes the read pointer after the 2-flop synchronizer has brought it into the write clock domain, and from it produces registered full, almost-full and fill-level outputs. Its Gray pointer output `wptr` is what the read-side synchronizer samples.

## Interface
Parameters:
- `ADDR_W`, default 3: RAM address width; FIFO depth is 2^ADDR_W; pointers are ADDR_W+1 bits.
- `AFULL_THRESH`, default 6: fill level at or above which `walmost_full` asserts; legal range 1..2^ADDR_W.

Ports:
- `clk`  in  1: write-domain clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `wr_en`  in  1: write request from producer.
- `wq2_rptr`  in  ADDR_W+1: Gray read pointer, already synchronized into clk domain.
- `wr_accept`  out  1: RAM write strobe; combinational `wr_en & ~wfull`.
- `waddr`  out  ADDR_W: RAM write address; low ADDR_W bits of binary write pointer.
- `wptr`  out  ADDR_W+1: registered Gray write pointer, sent to read-side synchronizer.
- `wfull`  out  1: registered full flag.
- `walmost_full`  out  1: registered almost-full flag.
- `wlevel`  out  ADDR_W+1: registered fill level, 0..2^ADDR_W (pessimistic).
- `woverflow`  out  1: sticky overflow flag; present only with `WR_OVERFLOW_FLAG_EN`.

## Operation
- State registers: `wbin` (binary, ADDR_W+1 bits), `wptr` (Gray), `wfull`, `walmost_full`, `wlevel`.
- Reset (rst_n=0 at posedge clk): all registers clear to 0, so `wbin`, `wptr`, `wfull`, `walmost_full`, `wlevel` and `woverflow` are all 0. `wr_accept` is forced to 0 while rst_n=0.
- `wbin_next` = `wbin + wr_accept`, modulo 2^(ADDR_W+1); wraps naturally.
- `wgray_next` = `(wbin_next >> 1) ^ wbin_next`.
  - Only one Gray bit changes per accepted write; this is required for safe synchronization.
- Full test: `wfull_next` = (`wgray_next` == {~`wq2_rptr`[ADDR_W:ADDR_W-1], `wq2_rptr`[ADDR_W-2:0]}).
- Level:
  - `rbin` = Gray-to-binary of `wq2_rptr` (XOR prefix from MSB).
  - `wlevel_next` = `wbin_next - rbin`, modulo 2^(ADDR_W+1).
  - `walmost_full_next` = (`wlevel_next` >= AFULL_THRESH).
- Write while full: `wr_en=1` with `wfull=1` is dropped. Pointer, address and RAM are unchanged.
- Simultaneous write and read-pointer advance are handled naturally: both terms enter `*_next` in the same cycle.
- Reset mid-operation: pointers return to 0 on that edge. The read side is reset in the same system reset sequence; cross-domain consistency is the integrator's responsibility.

## Timing
- All outputs except `wr_accept` are registered and update on posedge clk.
- `waddr` is valid in the same cycle `wr_accept` is high; the RAM captures data on that edge.
- `wfull` asserts on the edge of the write that fills the FIFO, with zero bubble. It is visible the following cycle.
- `wfull` deasserts 1 cycle after a changed `wq2_rptr` arrives. That is at least 3 clk cycles after the read side advances: 2 synchronizer stages plus 1 register.
- `wlevel` and `walmost_full` carry the same latency. They are pessimistic: the level may be overstated, never understated.
- `wptr` changes 1 cycle after an accepted write.

## Configuration
- `WR_OVERFLOW_FLAG_EN` defined:
  - Adds output `woverflow`, set on the edge where `wr_en=1` and `wfull=1`.
  - The flag is sticky until rst_n=0.
- Not defined: port and logic are absent. Dropped writes are silent.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with `wr_en=1` -> `wptr`=0000, `wfull`=0, `wlevel`=0, `wr_accept`=0.
- Fill (ADDR_W=3), `wq2_rptr`=0000, 8 back-to-back writes:
  - `waddr` steps 0..7.
  - After 8th write: `wptr`=1100, `wfull`=1, `wlevel`=8.
  - `walmost_full` rises after the 6th write.
- Write when full: 9th `wr_en` -> `wr_accept`=0, `wptr` stays 1100. With `WR_OVERFLOW_FLAG_EN`, `woverflow`=1 and stays 1.
- Drain release: from full, drive `wq2_rptr`=0001 (rbin=1) -> next cycle `wfull`=0, `wlevel`=7. A write then moves `wptr` to 1101 and sets `wfull`=1.
- Wrap: run 20 writes against a tracking `wq2_rptr` -> `wbin` wraps 15→0. `wptr` changes exactly one bit per write, and the Gray sequence returns to 0000.
- Simultaneous: at `wlevel`=5 with `AFULL_THRESH`=6, write and advance `wq2_rptr` by one in the same cycle -> `wlevel` stays 5 and `walmost_full` stays 0.
